// File: rtl/prog_cntr_sel_ctrl_if.sv
// Purpose: request/status bundle between fetch control and the PC-select sequencer.
// Latency: none, wiring only.
// Backpressure: stall is carried as a plain level; no handshake in this bundle.
interface prog_cntr_sel_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic        ret_req;
  logic        reti_req;
  logic        int_en;
  logic        int_req;
  logic [2:0]  int_vector;
  logic [3:0]  sel_signals;
  logic        prog_cntr_load_en;
  logic        flush;
  logic        int_ack;
  logic [13:0] int_branch_addr;
  logic        in_isr;

  // Fetch/decode side: drives requests, observes the PC mux controls.
  modport master (
    output stall, branch_taken, ret_req, reti_req, int_en, int_req, int_vector,
    input  sel_signals, prog_cntr_load_en, flush, int_ack, int_branch_addr, in_isr
  );

  // Sequencer side.
  modport slave (
    input  stall, branch_taken, ret_req, reti_req, int_en, int_req, int_vector,
    output sel_signals, prog_cntr_load_en, flush, int_ack, int_branch_addr, in_isr
  );
endinterface

// File: rtl/prog_cntr_sel_ctrl.sv
// Purpose: PC-load sequencer choosing next PC / branch / return / interrupt vector; optional nesting via PC_SEL_NESTED_INT_EN.
// Latency: redirects are same-cycle; interrupt vector loads DRAIN_CYCLES+1 cycles after acceptance.
// Backpressure: stall holds the PC and defers every request; it freezes the drain counter and the vector load.
module prog_cntr_sel_ctrl #(
  parameter logic [13:0] INT_VEC_BASE = 14'h0004,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MAX_NEST     = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  prog_cntr_sel_ctrl_if.slave  pc_if
);

`ifdef PC_SEL_NESTED_INT_EN
  localparam int unsigned DW         = 3;
  localparam int unsigned NEST_LIMIT = MAX_NEST;
`else
  // Single-level build: depth is one bit, so the limit is at most one level.
  localparam int unsigned DW         = 1;
  localparam int unsigned NEST_LIMIT = (MAX_NEST > 1) ? 1 : MAX_NEST;
`endif

  localparam logic [DW-1:0] DEPTH_MAX  = DW'(NEST_LIMIT);
  localparam logic [3:0]    DRAIN_INIT = 4'(DRAIN_CYCLES);

  localparam logic [3:0] SEL_NEXT = 4'b0001;
  localparam logic [3:0] SEL_BR   = 4'b0010;
  localparam logic [3:0] SEL_INT  = 4'b0100;
  localparam logic [3:0] SEL_RET  = 4'b1000;

  typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_t;

  state_t         state_q, state_d;
  logic [3:0]     drain_cnt_q, drain_cnt_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic [13:0]    int_addr_q, int_addr_d;

  logic [3:0]  sel;
  logic        load_en;
  logic        flush;
  logic        ack;
  logic        masked;
  logic        accept;
  logic [13:0] vec_addr;

  // Vector table entries are 4 bytes apart; the sum wraps within the 14-bit PC space.
  assign vec_addr = INT_VEC_BASE + {9'd0, pc_if.int_vector, 2'b00};
  assign masked   = (depth_q == DEPTH_MAX);
  assign accept   = pc_if.int_req & pc_if.int_en & ~masked;

  // Next-state and same-cycle mux control decode, priority ordered in RUN.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    depth_d     = depth_q;
    int_addr_d  = int_addr_q;
    sel         = SEL_NEXT;
    load_en     = 1'b0;
    flush       = 1'b0;
    ack         = 1'b0;
    case (state_q)
      RUN: begin
        if (pc_if.stall) begin
          // Hold the PC; requests are levels and will be seen again.
          sel = SEL_NEXT;
        end else if (pc_if.reti_req) begin
          sel     = SEL_RET;
          load_en = 1'b1;
          flush   = 1'b1;
          if (depth_q != '0) depth_d = depth_q - DW'(1);
        end else if (pc_if.ret_req) begin
          sel     = SEL_RET;
          load_en = 1'b1;
          flush   = 1'b1;
        end else if (pc_if.branch_taken) begin
          sel     = SEL_BR;
          load_en = 1'b1;
          flush   = 1'b1;
        end else if (accept) begin
          ack         = 1'b1;
          flush       = 1'b1;
          int_addr_d  = vec_addr;
          drain_cnt_d = DRAIN_INIT;
          depth_d     = depth_q + DW'(1);
          state_d     = DRAIN;
        end else begin
          load_en = 1'b1;
        end
      end
      DRAIN: begin
        // Branch/return requests here belong to instructions being flushed.
        flush = 1'b1;
        if (!pc_if.stall) begin
          if (drain_cnt_q <= 4'd1) begin
            drain_cnt_d = 4'd0;
            state_d     = VECTOR;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
      end
      VECTOR: begin
        sel   = SEL_INT;
        flush = 1'b1;
        if (!pc_if.stall) begin
          load_en = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Sequencer state, drain counter, nesting depth and latched vector address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      drain_cnt_q <= 4'd0;
      depth_q     <= '0;
      int_addr_q  <= 14'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      depth_q     <= depth_d;
      int_addr_q  <= int_addr_d;
    end
  end

  // Controls are forced quiet while reset is asserted, independent of request inputs.
  assign pc_if.sel_signals       = reset_n ? sel : SEL_NEXT;
  assign pc_if.prog_cntr_load_en = load_en & reset_n;
  assign pc_if.flush             = flush & reset_n;
  assign pc_if.int_ack           = ack & reset_n;
  assign pc_if.int_branch_addr   = int_addr_q;
  assign pc_if.in_isr            = (depth_q != '0);

endmodule

// File: tb/tb_prog_cntr_sel_ctrl.sv
// Purpose: directed self-checking bench for prog_cntr_sel_ctrl (default and PC_SEL_NESTED_INT_EN builds).
// Latency: expectations are queued per cycle and compared mid-cycle.
// Backpressure: stall is exercised in RUN, DRAIN and VECTOR.
module tb_prog_cntr_sel_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  prog_cntr_sel_ctrl_if if1();
  prog_cntr_sel_ctrl_if if2();

  prog_cntr_sel_ctrl #(.INT_VEC_BASE(14'h0004), .DRAIN_CYCLES(2), .MAX_NEST(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .pc_if(if1)
  );

  prog_cntr_sel_ctrl #(.INT_VEC_BASE(14'h3FFC), .DRAIN_CYCLES(1), .MAX_NEST(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .pc_if(if2)
  );

  typedef struct {
    string       tag;
    int          d;
    logic [3:0]  sel;
    logic        ld;
    logic        fl;
    logic        ack;
    logic        isr;
    logic [13:0] addr;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the expected outputs for the current cycle, then compare at the falling edge.
  task automatic step(input string tag, input int d, input logic [3:0] sel,
                      input logic ld, input logic fl, input logic ack, input logic isr,
                      input logic [13:0] addr);
    exp_t e;
    logic [3:0]  o_sel;
    logic        o_ld, o_fl, o_ack, o_isr;
    logic [13:0] o_addr;
    e.tag = tag; e.d = d; e.sel = sel; e.ld = ld; e.fl = fl;
    e.ack = ack; e.isr = isr; e.addr = addr;
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    if (e.d == 1) begin
      o_sel = if1.sel_signals; o_ld = if1.prog_cntr_load_en; o_fl = if1.flush;
      o_ack = if1.int_ack; o_isr = if1.in_isr; o_addr = if1.int_branch_addr;
    end else begin
      o_sel = if2.sel_signals; o_ld = if2.prog_cntr_load_en; o_fl = if2.flush;
      o_ack = if2.int_ack; o_isr = if2.in_isr; o_addr = if2.int_branch_addr;
    end
    chk({e.tag, ".sel"},    32'(o_sel),  32'(e.sel));
    chk({e.tag, ".onehot"}, 32'($onehot(o_sel)), 32'd1);
    chk({e.tag, ".ld"},     32'(o_ld),   32'(e.ld));
    chk({e.tag, ".flush"},  32'(o_fl),   32'(e.fl));
    chk({e.tag, ".ack"},    32'(o_ack),  32'(e.ack));
    chk({e.tag, ".isr"},    32'(o_isr),  32'(e.isr));
    chk({e.tag, ".addr"},   32'(o_addr), 32'(e.addr));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    if1.stall = 0; if1.branch_taken = 0; if1.ret_req = 0; if1.reti_req = 0;
    if1.int_en = 0; if1.int_req = 0; if1.int_vector = 3'd0;
    if2.stall = 0; if2.branch_taken = 0; if2.ret_req = 0; if2.reti_req = 0;
    if2.int_en = 0; if2.int_req = 0; if2.int_vector = 3'd0;
    @(posedge clock); #1;

    // Reset state, with a live request that must not leak through.
    if1.branch_taken = 1;
    step("rst",  1, 4'b0001, 0, 0, 0, 0, 14'h0000);
    if1.branch_taken = 0;
    step("rst2", 2, 4'b0001, 0, 0, 0, 0, 14'h0000);
    reset_n = 1'b1;
    step("run",  1, 4'b0001, 1, 0, 0, 0, 14'h0000);

    // Branch beats a simultaneous interrupt; interrupt accepted next cycle.
    if1.branch_taken = 1; if1.int_req = 1; if1.int_en = 1; if1.int_vector = 3'd5;
    step("br_int", 1, 4'b0010, 1, 1, 0, 0, 14'h0000);
    if1.branch_taken = 0;
    step("acc",    1, 4'b0001, 0, 1, 1, 0, 14'h0000);
    // Redirect requests during drain are ignored.
    if1.int_req = 0; if1.ret_req = 1; if1.branch_taken = 1;
    step("drain1", 1, 4'b0001, 0, 1, 0, 1, 14'h0018);
    if1.ret_req = 0; if1.branch_taken = 0;
    step("drain2", 1, 4'b0001, 0, 1, 0, 1, 14'h0018);
    step("vec",    1, 4'b0100, 1, 1, 0, 1, 14'h0018);
    step("isr_run",1, 4'b0001, 1, 0, 0, 1, 14'h0018);

`ifndef PC_SEL_NESTED_INT_EN
    // Second request masked inside the ISR, accepted once RETI clears it.
    if1.int_req = 1; if1.int_vector = 3'd2;
    step("masked", 1, 4'b0001, 1, 0, 0, 1, 14'h0018);
    if1.reti_req = 1;
    step("reti",   1, 4'b1000, 1, 1, 0, 1, 14'h0018);
    if1.reti_req = 0;
    step("acc2",   1, 4'b0001, 0, 1, 1, 0, 14'h0018);
`else
    // Nested acceptance up to MAX_NEST=2, then masked.
    if1.int_req = 1; if1.int_vector = 3'd2;
    step("nest_acc", 1, 4'b0001, 0, 1, 1, 1, 14'h0018);
    if1.int_req = 0;
    step("nest_d1",  1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    step("nest_d2",  1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    step("nest_vec", 1, 4'b0100, 1, 1, 0, 1, 14'h000C);
    step("nest_run", 1, 4'b0001, 1, 0, 0, 1, 14'h000C);
    if1.int_req = 1; if1.int_vector = 3'd3;
    step("nest_mask",1, 4'b0001, 1, 0, 0, 1, 14'h000C);
    if1.int_req = 0; if1.reti_req = 1;
    step("nest_r1",  1, 4'b1000, 1, 1, 0, 1, 14'h000C);
    step("nest_r2",  1, 4'b1000, 1, 1, 0, 1, 14'h000C);
    if1.reti_req = 0; if1.int_req = 1; if1.int_vector = 3'd2;
    step("acc2",     1, 4'b0001, 0, 1, 1, 0, 14'h000C);
`endif

    // Stall in DRAIN freezes the counter; stall in VECTOR holds the load.
    if1.int_req = 0; if1.stall = 1;
    step("stl_d1", 1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    step("stl_d2", 1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    if1.stall = 0;
    step("stl_d3", 1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    step("stl_d4", 1, 4'b0001, 0, 1, 0, 1, 14'h000C);
    if1.stall = 1;
    step("vec_stl",1, 4'b0100, 0, 1, 0, 1, 14'h000C);
    if1.stall = 0;
    step("vec_go", 1, 4'b0100, 1, 1, 0, 1, 14'h000C);
    step("run2",   1, 4'b0001, 1, 0, 0, 1, 14'h000C);

    // RETI deferred by stall, then taken.
    if1.stall = 1; if1.reti_req = 1;
    step("run_stl",  1, 4'b0001, 0, 0, 0, 1, 14'h000C);
    if1.stall = 0;
    step("reti_def", 1, 4'b1000, 1, 1, 0, 1, 14'h000C);
    if1.reti_req = 0;
    step("isr_off",  1, 4'b0001, 1, 0, 0, 0, 14'h000C);

    // RETI at depth 0 acts as RET; plain RET; disabled interrupts ignored.
    if1.reti_req = 1;
    step("reti0",  1, 4'b1000, 1, 1, 0, 0, 14'h000C);
    if1.reti_req = 0; if1.ret_req = 1;
    step("ret",    1, 4'b1000, 1, 1, 0, 0, 14'h000C);
    if1.ret_req = 0; if1.int_en = 0; if1.int_req = 1;
    step("int_dis",1, 4'b0001, 1, 0, 0, 0, 14'h000C);

    // Async reset during DRAIN: back to RUN, depth cleared, no vector load.
    if1.int_en = 1; if1.int_vector = 3'd7;
    step("acc3",     1, 4'b0001, 0, 1, 1, 0, 14'h000C);
    if1.int_req = 0;
    step("drain_r",  1, 4'b0001, 0, 1, 0, 1, 14'h0020);
    reset_n = 1'b0;
    step("rst_drn",  1, 4'b0001, 0, 0, 0, 0, 14'h0000);
    reset_n = 1'b1;
    step("post_rst", 1, 4'b0001, 1, 0, 0, 0, 14'h0000);
    step("post_rs2", 1, 4'b0001, 1, 0, 0, 0, 14'h0000);

    // Second instance: base 0x3FFC, single drain cycle, address wrap.
    if2.int_en = 1; if2.int_req = 1; if2.int_vector = 3'd0;
    step("w_acc0", 2, 4'b0001, 0, 1, 1, 0, 14'h0000);
    if2.int_req = 0;
    step("w_drn0", 2, 4'b0001, 0, 1, 0, 1, 14'h3FFC);
    step("w_vec0", 2, 4'b0100, 1, 1, 0, 1, 14'h3FFC);
    step("w_run",  2, 4'b0001, 1, 0, 0, 1, 14'h3FFC);
    if2.reti_req = 1;
    step("w_reti", 2, 4'b1000, 1, 1, 0, 1, 14'h3FFC);
    if2.reti_req = 0; if2.int_req = 1; if2.int_vector = 3'd1;
    step("w_acc1", 2, 4'b0001, 0, 1, 1, 0, 14'h3FFC);
    if2.int_req = 0;
    step("w_drn1", 2, 4'b0001, 0, 1, 0, 1, 14'h0000);
    step("w_vec1", 2, 4'b0100, 1, 1, 0, 1, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
